// File: rtl/voter_pkg.sv
// voter_pkg: shared state encoding and decision-rule constants for the voter tally
package voter_pkg;
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_t;
  localparam int MODE_SIMPLE = 0;
  localparam int MODE_ABS    = 1;
  localparam int MODE_UNAN   = 2;
endpackage

// File: rtl/voter_popcount.sv
// voter_popcount: combinational count of set bits in an N-wide vector
module voter_popcount #(
  parameter int N     = 4,
  parameter int CNT_W = $clog2(N + 1)
) (
  input  logic [N-1:0]     i_bits,
  output logic [CNT_W-1:0] o_cnt
);
  // sum every bit into the count
  always_comb begin
    o_cnt = '0;
    for (int i = 0; i < N; i++) o_cnt = o_cnt + CNT_W'(i_bits[i]);
  end
endmodule

// File: rtl/voter_tally.sv
// voter_tally: per-session yes/no/abstain tally with selectable decision rule
module voter_tally
  import voter_pkg::*;
#(
  parameter int N_VOTERS = 4,
  parameter int CNT_W    = $clog2(N_VOTERS + 1),
  parameter int MODE     = 0,
  parameter int TIMEOUT  = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [N_VOTERS-1:0] cast,
  input  logic [N_VOTERS-1:0] yes,
  input  logic                close,
  output logic                busy,
  output logic [CNT_W-1:0]    yes_cnt,
  output logic [CNT_W-1:0]    no_cnt,
  output logic [CNT_W-1:0]    abstain_cnt,
  output logic                pass,
  output logic                tie,
  output logic                result_valid,
  output logic                dup_err
);
  state_t              r_state, w_next;
  logic [N_VOTERS-1:0] r_voted, w_acc;
  logic [CNT_W-1:0]    r_yes, r_no, r_abst, w_pop_yes, w_pop_no, w_yes_nxt, w_no_nxt;
  logic                r_pass, r_tie, r_valid, r_dup;
  logic                w_collect, w_open, w_close, w_tmo, w_pass;

  assign w_collect = (r_state == S_COLLECT);
  assign w_open    = (r_state == S_IDLE) && start;
  assign w_acc     = w_collect ? (cast & ~r_voted) : '0;

  voter_popcount #(.N(N_VOTERS), .CNT_W(CNT_W)) u_pop_yes (.i_bits(w_acc & yes),  .o_cnt(w_pop_yes));
  voter_popcount #(.N(N_VOTERS), .CNT_W(CNT_W)) u_pop_no  (.i_bits(w_acc & ~yes), .o_cnt(w_pop_no));

  assign w_yes_nxt = r_yes + w_pop_yes;
  assign w_no_nxt  = r_no + w_pop_no;

  // auto-close timer only exists when a timeout is configured
  if (TIMEOUT > 0) begin : g_tmr
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] r_timer;
    // count cycles spent in COLLECT, restarting when a session opens
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_timer <= '0;
      else if (w_open) r_timer <= '0;
      else if (w_collect) r_timer <= r_timer + 1'b1;
    assign w_tmo = w_collect && (r_timer == TW'(TIMEOUT - 1));
  end else begin : g_no_tmr
    assign w_tmo = 1'b0;
  end

  // session ends on explicit close, all voters in (including this cycle's casts), or timeout
  always_comb begin
    w_close = w_collect && (close || (&(r_voted | w_acc)) || w_tmo);
    w_pass  = (MODE == MODE_UNAN) ? (w_yes_nxt == CNT_W'(N_VOTERS)) :
              (MODE == MODE_ABS)  ? ({w_yes_nxt, 1'b0} > (CNT_W + 1)'(N_VOTERS)) :
                                    (w_yes_nxt > w_no_nxt);
    w_next  = w_open  ? S_COLLECT :
              w_close ? S_DONE :
              (r_state == S_DONE) ? S_IDLE : r_state;
  end

  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_next;

  // tallies, duplicate detection and the result latched at the closing edge so it is valid with result_valid
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_voted <= '0;
      r_yes   <= '0;
      r_no    <= '0;
      r_abst  <= '0;
      r_pass  <= 1'b0;
      r_tie   <= 1'b0;
      r_valid <= 1'b0;
      r_dup   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_dup   <= 1'b0;
      if (w_open) begin
        r_voted <= '0;
        r_yes   <= '0;
        r_no    <= '0;
        r_pass  <= 1'b0;
        r_tie   <= 1'b0;
      end else if (w_collect) begin
        r_voted <= r_voted | w_acc;
        r_yes   <= w_yes_nxt;
        r_no    <= w_no_nxt;
        r_dup   <= |(cast & r_voted);
        if (w_close) begin
          r_valid <= 1'b1;
          r_pass  <= w_pass;
          r_tie   <= (w_yes_nxt == w_no_nxt);
          r_abst  <= CNT_W'(N_VOTERS) - w_yes_nxt - w_no_nxt;
        end
      end
    end

  assign busy         = w_collect;
  assign yes_cnt      = r_yes;
  assign no_cnt       = r_no;
  assign abstain_cnt  = r_abst;
  assign pass         = r_pass;
  assign tie          = r_tie;
  assign result_valid = r_valid;
  assign dup_err      = r_dup;
endmodule

// File: tb/tb_voter_tally.sv
// tb_voter_tally: table-driven check of voter_tally in three decision modes plus timeout and reset sequences
module tb_voter_tally;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, close = 1'b0, start_t = 1'b0;
  logic [3:0] cast = '0, yes = '0;
  logic [3:0] busy_v, pass_v, tie_v, rv_v, dup_v;
  logic [2:0] yc [4];
  logic [2:0] nc [4];
  logic [2:0] ac [4];
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  voter_tally #(.N_VOTERS(4), .MODE(0)) u0 (.clk(clk), .rst_n(rst_n), .start(start), .cast(cast), .yes(yes),
    .close(close), .busy(busy_v[0]), .yes_cnt(yc[0]), .no_cnt(nc[0]), .abstain_cnt(ac[0]), .pass(pass_v[0]),
    .tie(tie_v[0]), .result_valid(rv_v[0]), .dup_err(dup_v[0]));
  voter_tally #(.N_VOTERS(4), .MODE(1)) u1 (.clk(clk), .rst_n(rst_n), .start(start), .cast(cast), .yes(yes),
    .close(close), .busy(busy_v[1]), .yes_cnt(yc[1]), .no_cnt(nc[1]), .abstain_cnt(ac[1]), .pass(pass_v[1]),
    .tie(tie_v[1]), .result_valid(rv_v[1]), .dup_err(dup_v[1]));
  voter_tally #(.N_VOTERS(4), .MODE(2)) u2 (.clk(clk), .rst_n(rst_n), .start(start), .cast(cast), .yes(yes),
    .close(close), .busy(busy_v[2]), .yes_cnt(yc[2]), .no_cnt(nc[2]), .abstain_cnt(ac[2]), .pass(pass_v[2]),
    .tie(tie_v[2]), .result_valid(rv_v[2]), .dup_err(dup_v[2]));
  voter_tally #(.N_VOTERS(4), .MODE(0), .TIMEOUT(8)) u3 (.clk(clk), .rst_n(rst_n), .start(start_t),
    .cast(4'd0), .yes(4'd0), .close(1'b0), .busy(busy_v[3]), .yes_cnt(yc[3]), .no_cnt(nc[3]),
    .abstain_cnt(ac[3]), .pass(pass_v[3]), .tie(tie_v[3]), .result_valid(rv_v[3]), .dup_err(dup_v[3]));

  typedef struct {
    logic       st;
    logic [3:0] ca;
    logic [3:0] ye;
    logic       cl;
    logic       busy;
    int         ycnt;
    int         ncnt;
    int         acnt;
    logic       tie;
    logic       p0;
    logic       p1;
    logic       p2;
    logic       rv;
    logic       dup;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string name, input int row, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s row %0d: got %0d expected %0d", name, row, act, exp);
    end
  endtask

  initial begin
    int got;
    // st ca ye cl | busy yes no abst tie p0 p1 p2 rv dup
    tbl[0]  = '{1'b1, 4'hf, 4'hf, 1'b0, 1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 4'h3, 4'h1, 1'b0, 1'b1, 1, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 4'hc, 4'h4, 1'b0, 1'b0, 2, 2, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 2, 2, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 4'h0, 4'h0, 1'b0, 1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 4'h1, 4'h1, 1'b0, 1'b1, 1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 4'h1, 4'h0, 1'b0, 1'b1, 1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1, 0, 3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1, 0, 3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 4'h0, 4'h0, 1'b0, 1'b1, 0, 0, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 4'h7, 4'h3, 1'b1, 1'b0, 2, 1, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 4'hf, 4'hf, 1'b1, 1'b0, 2, 1, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 4'hf, 4'hf, 1'b1, 1'b0, 2, 1, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 4'h0, 4'h0, 1'b0, 1'b1, 0, 0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 4'hf, 4'hf, 1'b0, 1'b0, 4, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[16] = '{1'b1, 4'h0, 4'h0, 1'b0, 1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 0, 0, 4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[18] = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 0, 0, 4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", -1, int'(busy_v), 0);
    chk("reset flags", -1, int'({pass_v, tie_v, rv_v, dup_v}), 0);
    chk("reset counts", -1, int'({yc[0], nc[0], ac[0]}), 0);
    @(negedge clk) rst_n = 1'b1;

    for (int r = 0; r < 19; r++) begin
      @(negedge clk);
      start = tbl[r].st; cast = tbl[r].ca; yes = tbl[r].ye; close = tbl[r].cl;
      @(posedge clk);
      #1;
      chk("busy", r, int'(busy_v[0]), int'(tbl[r].busy));
      chk("yes_cnt", r, int'(yc[0]), tbl[r].ycnt);
      chk("no_cnt", r, int'(nc[0]), tbl[r].ncnt);
      chk("abstain_cnt", r, int'(ac[0]), tbl[r].acnt);
      chk("tie", r, int'(tie_v[0]), int'(tbl[r].tie));
      chk("pass mode0", r, int'(pass_v[0]), int'(tbl[r].p0));
      chk("pass mode1", r, int'(pass_v[1]), int'(tbl[r].p1));
      chk("pass mode2", r, int'(pass_v[2]), int'(tbl[r].p2));
      chk("result_valid", r, int'(rv_v[2:0]), tbl[r].rv ? 7 : 0);
      chk("dup_err", r, int'(dup_v[0]), int'(tbl[r].dup));
    end

    // reset in the middle of a session aborts it with everything cleared
    @(negedge clk);
    start = 1'b1; cast = '0; yes = '0; close = 1'b0;
    @(negedge clk);
    start = 1'b0; cast = 4'h3; yes = 4'h1;
    @(posedge clk);
    #1;
    chk("pre-reset yes_cnt", 100, int'(yc[0]), 1);
    chk("pre-reset busy", 100, int'(busy_v[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid reset busy", 101, int'(busy_v), 0);
    chk("mid reset counts", 101, int'({yc[0], nc[0], ac[0]}), 0);
    chk("mid reset flags", 101, int'({pass_v, tie_v, rv_v, dup_v}), 0);
    @(negedge clk);
    cast = '0; yes = '0;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("no result after reset", 102 + k, int'(rv_v), 0);
    end

    // timeout of 8: pulse lands in the 9th cycle after the start edge; a second start is ignored
    @(negedge clk) start_t = 1'b1;
    @(posedge clk);
    #1;
    chk("timeout busy at start", 200, int'(busy_v[3]), 1);
    got = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk) start_t = (k == 3);
      @(posedge clk);
      #1;
      if (rv_v[3]) begin
        got = k;
        break;
      end
      chk("timeout busy held", 200 + k, int'(busy_v[3]), 1);
    end
    chk("timeout valid cycle", 220, got + 1, 9);
    @(negedge clk) start_t = 1'b0;
    @(posedge clk);
    #1;
    chk("timeout valid pulse width", 221, int'({rv_v[3], busy_v[3]}), 0);
    chk("timeout empty tie/abst", 222, int'({tie_v[3], ac[3]}), 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
